// File: rtl/exec_unit_seq.sv
// exec_unit_seq: handshaked execute unit, single-cycle logic ops, iterative shifts/rotates, sticky trap
module exec_unit_seq #(
    parameter int WIDTH   = 20,
    parameter int SHAMT_W = 5,
    parameter int OPC_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] w,
    output logic             illegal,
    output logic             trap
);
    localparam int CNT_W = SHAMT_W + 1;
    localparam logic [OPC_W-1:0] OP_TRAP  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_NOP   = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_NOT   = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_OR    = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_XOR   = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_SHFTR = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_SHFTL = OPC_W'(13);
    localparam logic [OPC_W-1:0] OP_ROTR  = OPC_W'(14);

    typedef enum logic [1:0] {IDLE, SHIFT, TRAPPED} state_t;

    state_t             r_state, w_state_nx;
    logic [WIDTH-1:0]   r_acc, r_w, w_step, w_logic, w_load_val;
    logic [CNT_W-1:0]   r_cnt, w_amt, w_n;
    logic [OPC_W-1:0]   r_op;
    logic               r_ov, r_ill, r_trap;
    logic               w_accept, w_drain, w_is_logic, w_is_shift, w_legal, w_load, w_load_ill, w_shift_done;

    assign in_ready  = (r_state == IDLE) & (~r_ov | out_ready);
    assign out_valid = r_ov;
    assign w         = r_w;
    assign illegal   = r_ill;
    assign trap      = r_trap;

    always_comb begin
        w_accept     = in_valid & in_ready;
        w_drain      = r_ov & out_ready;
        w_is_logic   = opcode >= OP_NOT && opcode <= OP_XOR;
        w_is_shift   = opcode >= OP_SHFTR && opcode <= OP_ROTR;
        w_legal      = w_is_logic | w_is_shift | opcode == OP_TRAP | opcode == OP_NOP;
        w_amt        = {1'b0, b[SHAMT_W-1:0]};
        // rotate keeps the raw amount so the iteration naturally wraps modulo WIDTH
        w_n          = (opcode == OP_ROTR || w_amt < CNT_W'(WIDTH)) ? w_amt : CNT_W'(WIDTH);
        w_logic      = opcode == OP_NOT ? ~a : opcode == OP_AND ? a & b : opcode == OP_OR ? a | b : a ^ b;
        w_step       = r_op == OP_SHFTR ? r_acc >> 1 : r_op == OP_SHFTL ? r_acc << 1 : {r_acc[0], r_acc[WIDTH-1:1]};
        w_shift_done = r_state == SHIFT && r_cnt == CNT_W'(1);
        w_load       = w_shift_done | (w_accept & opcode != OP_TRAP & opcode != OP_NOP & (~w_is_shift | w_n == '0));
        w_load_val   = w_shift_done ? w_step : w_is_shift ? a : w_is_logic ? w_logic : '0;
        w_load_ill   = ~w_shift_done & ~w_legal;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    w_state_nx = !w_accept ? IDLE : opcode == OP_TRAP ? TRAPPED :
                                  (w_is_shift && w_n != '0) ? SHIFT : IDLE;
            SHIFT:   w_state_nx = w_shift_done ? IDLE : SHIFT;
            default: w_state_nx = TRAPPED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w    <= '0;
            r_ill  <= 1'b0;
            r_ov   <= 1'b0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_op   <= '0;
            r_trap <= 1'b0;
        end else begin
            if (w_load) begin
                r_w   <= w_load_val;
                r_ill <= w_load_ill;
                r_ov  <= 1'b1;
            end else if (w_drain) begin
                r_ov  <= 1'b0;
            end
            if (w_accept && w_is_shift) begin
                r_acc <= a;
                r_op  <= opcode;
                r_cnt <= w_n;
            end else if (r_state == SHIFT) begin
                r_acc <= w_step;
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_accept && opcode == OP_TRAP) r_trap <= 1'b1;
        end
    end
endmodule

// File: tb/tb_exec_unit_seq.sv
// tb_exec_unit_seq: randomized self-checking bench against an arithmetic reference model
module tb_exec_unit_seq;
    logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, illegal, trap;
    logic [4:0]  opcode = '0;
    logic [19:0] a = '0, b = '0, w;
    int          n_pass = 0, n_total = 0;

    exec_unit_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .w(w),
        .illegal(illegal), .trap(trap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [20:0] model(input logic [4:0] op, input logic [19:0] x, input logic [19:0] y);
        logic [39:0] d;
        int n;
        n = int'(y[4:0]);
        d = {x, x};
        if (op == 8)  return {1'b0, ~x};
        if (op == 9)  return {1'b0, x & y};
        if (op == 10) return {1'b0, x | y};
        if (op == 11) return {1'b0, x ^ y};
        if (op == 12) return {1'b0, n >= 20 ? 20'h0 : x >> n};
        if (op == 13) return {1'b0, n >= 20 ? 20'h0 : x << n};
        if (op == 14) return {1'b0, d[(n % 20) +: 20]};
        return {1'b1, 20'h0};
    endfunction

    function automatic int latency(input logic [4:0] op, input logic [19:0] y);
        int n;
        n = int'(y[4:0]);
        if (op == 12 || op == 13) return (n > 20 ? 20 : n) + 1;
        if (op == 14) return n + 1;
        return 1;
    endfunction

    task automatic issue(input logic [4:0] op, input logic [19:0] x, input logic [19:0] y,
                         output logic [19:0] ow, output logic oill, output int cyc, output int rdy);
        int g = 0;
        while (!in_ready && g < 50) begin tick(); g++; end
        opcode = op; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 1; rdy = 0;
        while (!out_valid && cyc < 100) begin
            rdy += int'(in_ready);
            tick();
            cyc++;
        end
        ow = w; oill = illegal;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_total += 5;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        if (trap !== 1'b0)      $display("FAIL reset_trap: got %b want 0", trap); else n_pass++;
        if (in_ready !== 1'b1)  $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        if (w !== 20'h0)        $display("FAIL reset_w: got %h want 0", w); else n_pass++;
        if (illegal !== 1'b0)   $display("FAIL reset_illegal: got %b want 0", illegal); else n_pass++;
    endtask

    task automatic run_and_check(input string nm, input logic [4:0] op, input logic [19:0] x, input logic [19:0] y);
        logic [19:0] ow; logic oill; int cyc, rdy;
        logic [20:0] e;
        e = model(op, x, y);
        issue(op, x, y, ow, oill, cyc, rdy);
        n_total += 4;
        if (ow !== e[19:0]) $display("FAIL %s_w op=%0d a=%h b=%h: got %h want %h", nm, op, x, y, ow, e[19:0]); else n_pass++;
        if (oill !== e[20]) $display("FAIL %s_illegal op=%0d: got %b want %b", nm, op, oill, e[20]); else n_pass++;
        if (cyc !== latency(op, y)) $display("FAIL %s_latency op=%0d b=%h: got %0d want %0d", nm, op, y, cyc, latency(op, y)); else n_pass++;
        if (rdy !== 0) $display("FAIL %s_busy_ready op=%0d: got %0d ready cycles want 0", nm, op, rdy); else n_pass++;
    endtask

    task automatic test_logic();
        run_and_check("and_dir", 5'd9, 20'hF0F0F, 20'h0FF00);
        for (int i = 0; i < 20; i++)
            run_and_check("logic_rnd", 5'($urandom_range(8, 11)), 20'($urandom), 20'($urandom));
    endtask

    task automatic test_shift();
        run_and_check("shftr_dir", 5'd12, 20'h80000, 20'd4);
        run_and_check("shftl_dir", 5'd13, 20'h12345, 20'd31);
        run_and_check("rotr_dir", 5'd14, 20'h00001, 20'd21);
        run_and_check("shift_zero", 5'd12, 20'hABCDE, 20'h00020);
        run_and_check("rotr_20", 5'd14, 20'h5A5A1, 20'd20);
        for (int i = 0; i < 25; i++)
            run_and_check("shift_rnd", 5'($urandom_range(12, 14)), 20'($urandom), 20'($urandom));
    endtask

    task automatic test_illegal();
        int seen = 0;
        run_and_check("jmp", 5'd2, 20'h12345, 20'h6789A);
        for (int i = 0; i < 6; i++) begin
            logic [4:0] op;
            op = 5'($urandom_range(15, 31));
            if (i % 2 == 0) op = 5'($urandom_range(3, 7));
            run_and_check("illegal_rnd", op, 20'($urandom), 20'($urandom));
        end
        opcode = 5'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin seen += int'(out_valid); tick(); end
        n_total += 3;
        if (seen !== 0)       $display("FAIL nop_out_valid: got %0d valid cycles want 0", seen); else n_pass++;
        if (in_ready !== 1'b1) $display("FAIL nop_in_ready: got %b want 1", in_ready); else n_pass++;
        if (trap !== 1'b0)    $display("FAIL nop_trap: got %b want 0", trap); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [19:0] x, y, z;
        logic [20:0] e;
        x = 20'($urandom); y = 20'($urandom); z = 20'($urandom);
        out_ready = 1'b0;
        opcode = 5'd11; a = x; b = y; in_valid = 1'b1;
        tick();
        opcode = 5'd8; a = z;
        n_total += 1;
        if (out_valid !== 1'b1 || w !== (x ^ y)) $display("FAIL bp_first: got v=%b w=%h want v=1 w=%h", out_valid, w, x ^ y); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total += 2;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else n_pass++;
            if (out_valid !== 1'b1 || w !== (x ^ y)) $display("FAIL bp_hold: got v=%b w=%h want v=1 w=%h", out_valid, w, x ^ y); else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_total += 2;
        if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        if (out_valid !== 1'b1 || w !== ~z) $display("FAIL bp_not: got v=%b w=%h want v=1 w=%h", out_valid, w, ~z); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            opcode = 5'($urandom_range(8, 11)); a = 20'($urandom); b = 20'($urandom); in_valid = 1'b1;
            e = model(opcode, a, b);
            n_total += 2;
            if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", in_ready); else n_pass++;
            tick();
            if (out_valid !== 1'b1 || w !== e[19:0]) $display("FAIL b2b_w: got v=%b w=%h want v=1 w=%h", out_valid, w, e[19:0]); else n_pass++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_trap();
        int rdy = 0, ov = 0;
        opcode = 5'd0; in_valid = 1'b1;
        tick();
        opcode = 5'd9; a = 20'hFFFFF; b = 20'hFFFFF;
        n_total += 3;
        if (trap !== 1'b1) $display("FAIL trap_set: got %b want 1", trap); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            rdy += int'(in_ready); ov += int'(out_valid);
            tick();
        end
        in_valid = 1'b0;
        if (rdy !== 0) $display("FAIL trap_in_ready: got %0d ready cycles want 0", rdy); else n_pass++;
        if (ov !== 0 || trap !== 1'b1) $display("FAIL trap_sticky: got valid=%0d trap=%b want 0 1", ov, trap); else n_pass++;
    endtask

    task automatic test_rst_mid_shift();
        int ov = 0;
        rst = 1'b1; tick(); rst = 1'b0;
        opcode = 5'd12; a = 20'hFFFFF; b = 20'd10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        n_total += 3;
        if (in_ready !== 1'b1 || trap !== 1'b0) $display("FAIL rst_shift_idle: got rdy=%b trap=%b want 1 0", in_ready, trap); else n_pass++;
        for (int i = 0; i < 15; i++) begin ov += int'(out_valid); tick(); end
        if (ov !== 0) $display("FAIL rst_shift_no_result: got %0d valid cycles want 0", ov); else n_pass++;
        if (w !== 20'h0) $display("FAIL rst_shift_w: got %h want 0", w); else n_pass++;
        run_and_check("post_rst", 5'd10, 20'h0F0F0, 20'h00F0F);
    endtask

    initial begin
        test_reset();
        test_logic();
        test_shift();
        test_illegal();
        test_back_to_back();
        test_trap();
        test_rst_mid_shift();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
